// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the execute-stage ALU and its condition evaluator.
// Provides the icode, ALU-function and condition-code constants, plus the condition-code flag record.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] A_ADD = 4'h0;
    localparam logic [3:0] A_SUB = 4'h1;
    localparam logic [3:0] A_AND = 4'h2;
    localparam logic [3:0] A_XOR = 4'h3;

    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    // Packed so that the record reads directly as {ZF,SF,OF}.
    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/y86_cond_eval.sv
// Combinational branch/move condition evaluator: maps a condition function code and
// the current ZF/SF/OF flags to a single taken/move decision.
module y86_cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] i_ifun,
    input  logic       i_zf,
    input  logic       i_sf,
    input  logic       i_of,
    output logic       o_cnd
);

    logic w_lt;

    // Signed "less than" after a subtraction is the sign corrected by overflow.
    assign w_lt = i_sf ^ i_of;

    always_comb begin
        o_cnd = 1'b0;
        case (i_ifun)
            C_ALWAYS: o_cnd = 1'b1;
            C_LE:     o_cnd = w_lt | i_zf;
            C_L:      o_cnd = w_lt;
            C_E:      o_cnd = i_zf;
            C_NE:     o_cnd = ~i_zf;
            C_GE:     o_cnd = ~w_lt;
            C_G:      o_cnd = ~w_lt & ~i_zf;
            default:  o_cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/y86_alu.sv
// Execute-stage ALU of the sequential Y86-64 core: computes valE and cnd one clock after
// a decode-complete strobe and owns the architectural condition codes.
module y86_alu
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          icode,
    input  logic [3:0]          ifun,
    input  logic signed [W-1:0] valA,
    input  logic signed [W-1:0] valB,
    input  logic signed [W-1:0] valC,
    output logic signed [W-1:0] valE,
    output logic                cnd,
    input  logic                d_com,
    output logic                e_com,
    output logic [2:0]          cc
);

    localparam logic signed [W-1:0] STACK_STEP = W'(8);

    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic e_msb);
        return (a_msb == b_msb) && (e_msb != b_msb);
    endfunction

    // Subtraction is valB - valA, so overflow needs operands of differing sign.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic e_msb);
        return (a_msb != b_msb) && (e_msb != b_msb);
    endfunction

    logic signed [W-1:0] r_valE;
    logic                r_cnd;
    logic                r_ecom;
    cc_t                 r_cc;

    logic signed [W-1:0] w_sum;
    logic signed [W-1:0] w_diff;
    logic signed [W-1:0] w_valE;
    logic                w_set_cc;
    logic                w_of;
    cc_t                 w_cc_next;
    logic                w_cond;
    logic                w_cnd_next;

    assign w_sum  = valB + valA;
    assign w_diff = valB - valA;

    always_comb begin
        w_valE   = '0;
        w_set_cc = 1'b0;
        w_of     = 1'b0;
        case (icode)
            I_RRMOVQ:          w_valE = valA;
            I_IRMOVQ:          w_valE = valC;
            I_RMMOVQ, I_MRMOVQ: w_valE = valB + valC;
            I_OPQ: begin
                case (ifun)
                    A_ADD: begin
                        w_valE   = w_sum;
                        w_set_cc = 1'b1;
                        w_of     = add_ovf(valA[W-1], valB[W-1], w_sum[W-1]);
                    end
                    A_SUB: begin
                        w_valE   = w_diff;
                        w_set_cc = 1'b1;
                        w_of     = sub_ovf(valA[W-1], valB[W-1], w_diff[W-1]);
                    end
                    A_AND: begin
                        w_valE   = valB & valA;
                        w_set_cc = 1'b1;
                    end
                    A_XOR: begin
                        w_valE   = valB ^ valA;
                        w_set_cc = 1'b1;
                    end
                    default: w_valE = '0;
                endcase
            end
            I_CALL, I_PUSHQ:   w_valE = valB - STACK_STEP;
            I_RET, I_POPQ:     w_valE = valB + STACK_STEP;
            default:           w_valE = '0;
        endcase
    end

    always_comb begin
        w_cc_next = r_cc;
        if (w_set_cc) begin
            w_cc_next.zf = (w_valE == '0);
            w_cc_next.sf = w_valE[W-1];
            w_cc_next.of = w_of;
        end
    end

    // Conditions look at the flags left by the previous OPq, never the one in flight.
    y86_cond_eval u_cond_eval (
        .i_ifun (ifun),
        .i_zf   (r_cc.zf),
        .i_sf   (r_cc.sf),
        .i_of   (r_cc.of),
        .o_cnd  (w_cond)
    );

    assign w_cnd_next = ((icode == I_RRMOVQ) || (icode == I_JXX)) ? w_cond : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valE <= '0;
            r_cnd  <= 1'b0;
            r_ecom <= 1'b0;
            r_cc   <= CC_RESET;
        end else if (d_com) begin
            r_valE <= w_valE;
            r_cnd  <= w_cnd_next;
            r_ecom <= 1'b1;
            r_cc   <= w_cc_next;
        end else begin
            r_ecom <= 1'b0;
        end
    end

    assign valE  = r_valE;
    assign cnd   = r_cnd;
    assign e_com = r_ecom;
    assign cc    = r_cc;

endmodule

// File: tb/tb_y86_alu.sv
// Bench for y86_alu: directed Y86-64 scenarios followed by random traffic, each cycle
// compared against a behavioural reference built from plain wide arithmetic.
module tb_y86_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic [63:0] valE;
    logic        cnd;
    logic        d_com;
    logic        e_com;
    logic [2:0]  cc;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] m_valE;
    logic        m_cnd;
    logic        m_ecom;
    logic        m_zf, m_sf, m_of;

    y86_alu #(.W(64)) dut (
        .clk   (clk),
        .rst   (rst),
        .icode (icode),
        .ifun  (ifun),
        .valA  (valA),
        .valB  (valB),
        .valC  (valC),
        .valE  (valE),
        .cnd   (cnd),
        .d_com (d_com),
        .e_com (e_com),
        .cc    (cc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: signed results held one bit wider, so overflow is simply "the
    // true result does not fit in 64 bits".
    task automatic model(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic dc, input logic rs);
        logic signed [64:0] wide;
        logic [63:0] e;
        logic wr, ovf, lt, cond;
        if (rs) begin
            m_valE = 64'd0; m_cnd = 1'b0; m_ecom = 1'b0;
            m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
            return;
        end
        if (!dc) begin
            m_ecom = 1'b0;
            return;
        end
        e = 64'd0; wr = 1'b0; ovf = 1'b0;
        case (ic)
            4'h2: e = a;
            4'h3: e = c;
            4'h4, 4'h5: e = b + c;
            4'h6: begin
                case (fn)
                    4'h0: begin
                        wide = $signed({b[63], b}) + $signed({a[63], a});
                        e = wide[63:0]; wr = 1'b1;
                        ovf = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000);
                    end
                    4'h1: begin
                        wide = $signed({b[63], b}) - $signed({a[63], a});
                        e = wide[63:0]; wr = 1'b1;
                        ovf = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000);
                    end
                    4'h2: begin e = b & a; wr = 1'b1; end
                    4'h3: begin e = b ^ a; wr = 1'b1; end
                    default: e = 64'd0;
                endcase
            end
            4'h8, 4'hA: e = b - 64'd8;
            4'h9, 4'hB: e = b + 64'd8;
            default: e = 64'd0;
        endcase
        lt = m_sf ^ m_of;
        case (fn)
            4'h0: cond = 1'b1;
            4'h1: cond = lt || m_zf;
            4'h2: cond = lt;
            4'h3: cond = m_zf;
            4'h4: cond = !m_zf;
            4'h5: cond = !lt;
            4'h6: cond = !lt && !m_zf;
            default: cond = 1'b0;
        endcase
        m_cnd  = (ic == 4'h2 || ic == 4'h7) ? cond : 1'b0;
        m_valE = e;
        m_ecom = 1'b1;
        if (wr) begin
            m_zf = (e == 64'd0);
            m_sf = e[63];
            m_of = ovf;
        end
    endtask

    task automatic step(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                        input logic dc, input logic rs);
        icode = ic; ifun = fn; valA = a; valB = b; valC = c; d_com = dc; rst = rs;
        @(posedge clk);
        model(ic, fn, a, b, c, dc, rs);
        #1;
        chk({tag, ".valE"}, valE, m_valE);
        chk({tag, ".cnd"}, {63'd0, cnd}, {63'd0, m_cnd});
        chk({tag, ".e_com"}, {63'd0, e_com}, {63'd0, m_ecom});
        chk({tag, ".cc"}, {61'd0, cc}, {61'd0, m_zf, m_sf, m_of});
    endtask

    initial begin
        logic [3:0] ric, rfn;
        logic [63:0] ra, rb, rc;
        rst = 1'b1; d_com = 1'b0; icode = '0; ifun = '0; valA = '0; valB = '0; valC = '0;
        m_valE = '0; m_cnd = 1'b0; m_ecom = 1'b0; m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;

        step("reset", 4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
        chk("reset_cc_const", {61'd0, cc}, 64'd4);
        step("idle0", 4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);

        step("add", 4'h6, 4'h0, 64'd1, 64'd7, 64'd0, 1'b1, 1'b0);
        chk("add_const", valE, 64'd8);
        step("add_idle", 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);

        step("ovf_add", 4'h6, 4'h0, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b1, 1'b0);
        chk("ovf_const", valE, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("ovf_cc_const", {61'd0, cc}, 64'd1);
        step("jl", 4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0);
        chk("jl_const", {63'd0, cnd}, 64'd1);
        step("jg", 4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0);

        step("sub0", 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0);
        step("je", 4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0);
        step("jne", 4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0);
        step("cmov", 4'h2, 4'h0, 64'h55, 64'd0, 64'd0, 1'b1, 1'b0);
        chk("cmov_cc_const", {61'd0, cc}, 64'd4);

        step("rmmov", 4'h4, 4'h0, 64'd0, 64'h10, 64'h20, 1'b1, 1'b0);
        chk("rmmov_const", valE, 64'h30);
        step("call", 4'h8, 4'h0, 64'd0, 64'h100, 64'd0, 1'b1, 1'b0);
        step("popq", 4'hB, 4'h0, 64'd0, 64'hF8, 64'd0, 1'b1, 1'b0);
        chk("popq_const", valE, 64'h100);

        step("b2b0", 4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 1'b1, 1'b0);
        step("b2b1", 4'h6, 4'h3, 64'hF0F0, 64'h0FF0, 64'd0, 1'b1, 1'b0);
        step("b2b2", 4'h6, 4'h2, 64'hFF00, 64'h0FF0, 64'd0, 1'b1, 1'b0);
        step("hold", 4'h3, 4'h0, 64'd0, 64'd0, 64'hDEAD, 1'b0, 1'b0);
        step("rst_dcom", 4'h3, 4'h0, 64'd0, 64'd0, 64'hBEEF, 1'b1, 1'b1);

        for (int i = 0; i < 400; i++) begin
            ric = 4'($urandom_range(0, 15));
            rfn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
            if (($urandom & 3) == 0) begin
                ra = {$urandom, $urandom};
                rb = ra ^ {63'd0, 1'($urandom)};
            end else begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
            end
            rc = {$urandom, $urandom};
            step("rand", ric, rfn, ra, rb, rc, ($urandom_range(0, 4) != 0), ($urandom_range(0, 40) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
